// File: rtl/regfile_pkg.sv
// Shared widths and requester identifiers for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 2;
    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_slot.sv
// One-entry holding slot: full flag, address, data, and an age bit that is set
// while this entry was captured before the entry in the sibling slot.
module arb_slot
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              grant,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              other_load,
    input  logic              other_full_next,
    output logic              full_next,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              age
);

    logic age_next;

    assign full_next = load || (full && !grant);

    // Older only when this entry survives while the sibling takes a fresh one.
    always_comb begin
        age_next = 1'b0;
        if (full_next && other_full_next) begin
            if (load)
                age_next = 1'b0;
            else if (other_load)
                age_next = 1'b1;
            else
                age_next = age;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
            age  <= 1'b0;
        end else begin
            full <= full_next;
            age  <= age_next;
            if (load) begin
                addr <= in_addr;
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with one holding slot per requester.
// Define ARB_BYPASS_EN for a zero-latency path when both slots are empty.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ADDR_W-1:0]         a_addr,
    input  logic [DATA_W-1:0]         a_data,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic [DATA_W-1:0]         b_data,
    output logic                      reg_write_signal,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [(1 << ADDR_W)-1:0]  pending
);

    localparam int unsigned N_REGS = 1 << ADDR_W;

    logic              a_full, b_full, a_age, b_age;
    logic              a_full_next, b_full_next;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q;
    logic [DATA_W-1:0] a_data_q, b_data_q;
    logic              a_grant, b_grant, a_load, b_load;
    logic              a_bypass, b_bypass;
    req_id_e           rr_ptr;

`ifdef ARB_BYPASS_EN
    assign a_bypass = !reset && !a_full && !b_full && a_valid && !b_valid;
    assign b_bypass = !reset && !a_full && !b_full && b_valid && !a_valid;
`else
    assign a_bypass = 1'b0;
    assign b_bypass = 1'b0;
`endif

    assign a_ready = !a_full || a_grant;
    assign b_ready = !b_full || b_grant;
    assign a_load  = a_valid && a_ready && !a_bypass;
    assign b_load  = b_valid && b_ready && !b_bypass;

    // Equal age with both full means both were captured on the same edge.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (a_full && b_full) begin
            if (a_age != b_age)
                a_grant = a_age;
            else if (a_addr_q == b_addr_q)
                a_grant = 1'b1;
            else
                a_grant = (rr_ptr == REQ_A);
            b_grant = !a_grant;
        end else begin
            a_grant = a_full;
            b_grant = b_full;
        end
    end

    always_comb begin
        reg_write_signal = 1'b0;
        write_addr       = '0;
        write_data       = '0;
        if (a_grant) begin
            reg_write_signal = 1'b1;
            write_addr       = a_addr_q;
            write_data       = a_data_q;
        end else if (b_grant) begin
            reg_write_signal = 1'b1;
            write_addr       = b_addr_q;
            write_data       = b_data_q;
        end else if (a_bypass) begin
            reg_write_signal = 1'b1;
            write_addr       = a_addr;
            write_data       = a_data;
        end else if (b_bypass) begin
            reg_write_signal = 1'b1;
            write_addr       = b_addr;
            write_data       = b_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < N_REGS; i++)
            pending[i] = (a_full && (a_addr_q == ADDR_W'(i))) ||
                         (b_full && (b_addr_q == ADDR_W'(i)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= REQ_A;
        else if (a_grant || a_bypass)
            rr_ptr <= REQ_B;
        else if (b_grant || b_bypass)
            rr_ptr <= REQ_A;
    end

    arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
        .clk             (clk),
        .reset           (reset),
        .load            (a_load),
        .grant           (a_grant),
        .in_addr         (a_addr),
        .in_data         (a_data),
        .other_load      (b_load),
        .other_full_next (b_full_next),
        .full_next       (a_full_next),
        .full            (a_full),
        .addr            (a_addr_q),
        .data            (a_data_q),
        .age             (a_age)
    );

    arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
        .clk             (clk),
        .reset           (reset),
        .load            (b_load),
        .grant           (b_grant),
        .in_addr         (b_addr),
        .in_data         (b_data),
        .other_load      (a_load),
        .other_full_next (a_full_next),
        .full_next       (b_full_next),
        .full            (b_full),
        .addr            (b_addr_q),
        .data            (b_data_q),
        .age             (b_age)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a timestamp-ordered reference model predicts each cycle's write,
// ready and pending; a negedge monitor compares them with the arbiter outputs.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int unsigned AW = REG_ADDR_W;
    localparam int unsigned DW = REG_DATA_W;
    localparam int unsigned NR = NUM_REGS;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          reg_write_signal;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [NR-1:0] pending;

    logic          req_valid [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_data  [2];

    assign a_valid = req_valid[0];
    assign a_addr  = req_addr[0];
    assign a_data  = req_data[0];
    assign b_valid = req_valid[1];
    assign b_addr  = req_addr[1];
    assign b_data  = req_data[1];

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_addr           (a_addr),
        .a_data           (a_data),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .b_addr           (b_addr),
        .b_data           (b_data),
        .reg_write_signal (reg_write_signal),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .pending          (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit            full;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int unsigned   stamp;
    } mslot_t;

    wr_t           exp_q[$];
    mslot_t        ms [2];
    int            rr;
    bit            acc_last [2];
    bit            exp_ready [2];
    logic [NR-1:0] exp_pending;
    int unsigned   cyc;
    int            n_checks;
    int            n_fail;
    logic [DW-1:0] rf     [NR] = '{default: '0};
    logic [DW-1:0] rf_exp [NR] = '{default: '0};

    // Register file written from the arbiter's write port.
    always @(posedge clk)
        if (!reset && reg_write_signal)
            rf[write_addr] <= write_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Oldest capture wins; same-edge captures to one address go to A; otherwise rr.
    task automatic model_eval(output int win, output int byp);
        win = -1;
        byp = -1;
        if (reset)
            return;
        if (ms[0].full && ms[1].full) begin
            if (ms[0].stamp != ms[1].stamp)
                win = (ms[0].stamp < ms[1].stamp) ? 0 : 1;
            else if (ms[0].addr == ms[1].addr)
                win = 0;
            else
                win = rr;
        end else if (ms[0].full)
            win = 0;
        else if (ms[1].full)
            win = 1;
`ifdef ARB_BYPASS_EN
        else if (req_valid[0] && !req_valid[1])
            byp = 0;
        else if (req_valid[1] && !req_valid[0])
            byp = 1;
`endif
    endtask

    task automatic step();
        int  win, byp;
        bit  acc [2];
        wr_t e;
        cyc++;
        model_eval(win, byp);
        exp_pending = '0;
        for (int r = 0; r < 2; r++) begin
            exp_ready[r] = !ms[r].full || (win == r);
            if (ms[r].full)
                exp_pending[ms[r].addr] = 1'b1;
        end
        if (win >= 0) begin
            e = '{cyc, ms[win].addr, ms[win].data};
            exp_q.push_back(e);
            rf_exp[e.addr] = e.data;
        end else if (byp >= 0) begin
            e = '{cyc, req_addr[byp], req_data[byp]};
            exp_q.push_back(e);
            rf_exp[e.addr] = e.data;
        end
        for (int r = 0; r < 2; r++)
            acc[r] = !reset && req_valid[r] && exp_ready[r] && (byp != r);
        @(posedge clk);
        if (!reset) begin
            if (win >= 0) begin
                ms[win].full = 1'b0;
                rr = 1 - win;
            end
            if (byp >= 0)
                rr = 1 - byp;
            for (int r = 0; r < 2; r++)
                if (acc[r])
                    ms[r] = '{1'b1, req_addr[r], req_data[r], cyc};
        end
        for (int r = 0; r < 2; r++)
            acc_last[r] = acc[r] || (byp == r);
        #1;
    endtask

    task automatic drive(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r] = 1'b1;
        req_addr[r]  = a;
        req_data[r]  = d;
    endtask

    task automatic idle(input int n);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        ms[0].full   = 1'b0;
        ms[1].full   = 1'b0;
        rr           = 0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t e;
        check("a_ready", 32'(a_ready), 32'(exp_ready[0]));
        check("b_ready", 32'(b_ready), 32'(exp_ready[1]));
        check("pending", 32'(pending), 32'(exp_pending));
        if (reg_write_signal) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write (cycle %0d)",
                         write_addr, write_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(write_addr), 32'(e.addr));
                check("write_data", 32'(write_data), 32'(e.data));
            end
        end else begin
            check("idle_addr", 32'(write_addr), 32'd0);
            check("idle_data", 32'(write_data), 32'd0);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_write: got no write, required addr %0d data 0x%0h (cycle %0d)",
                         e.addr, e.data, cyc);
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        rr           = 0;
        ms[0]        = '{1'b0, '0, '0, 0};
        ms[1]        = '{1'b0, '0, '0, 0};
        acc_last[0]  = 1'b0;
        acc_last[1]  = 1'b0;
        exp_pending  = '0;
        req_addr[0]  = '0;
        req_addr[1]  = '0;
        req_data[0]  = '0;
        req_data[1]  = '0;
        do_reset(2);
        idle(1);

        // A alone
        drive(0, 2'd1, 16'h1234);
        step();
        idle(3);
        check("reg1_after_a", 32'(rf[1]), 32'h1234);

        // A and B same edge, distinct addresses; then again to see the pointer favour B
        drive(0, 2'd2, 16'h0011);
        drive(1, 2'd3, 16'h0022);
        step();
        idle(3);
        check("reg2_after_ab", 32'(rf[2]), 32'h0011);
        check("reg3_after_ab", 32'(rf[3]), 32'h0022);
        drive(0, 2'd1, 16'h0101);
        drive(1, 2'd2, 16'h0202);
        step();
        idle(3);

        // Same edge, same address
        drive(0, 2'd0, 16'hAAAA);
        drive(1, 2'd0, 16'hBBBB);
        step();
        idle(3);
        check("reg0_final", 32'(rf[0]), 32'hBBBB);

        // Continuous traffic from both, distinct addresses
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 2; r++)
                if (k == 0 || acc_last[r])
                    drive(r, AW'(r * 2 + k % 2), DW'($urandom));
            step();
        end
        idle(4);

        // Reset while both slots are full
        drive(0, 2'd1, 16'hDEAD);
        drive(1, 2'd2, 16'hBEEF);
        step();
        do_reset(2);
        idle(2);
        check("reg1_not_dead", 32'(rf[1] == 16'hDEAD), 32'd0);

        // B alone with empty slots
        drive(1, 2'd2, 16'h5555);
        step();
        idle(3);
        check("reg2_after_b", 32'(rf[2]), 32'h5555);

        // Random traffic with occasional reset
        repeat (400) begin
            if ($urandom_range(0, 49) == 0)
                do_reset(1 + int'($urandom_range(0, 1)));
            for (int r = 0; r < 2; r++)
                if (!req_valid[r] || acc_last[r]) begin
                    req_valid[r] = ($urandom_range(0, 99) < 65);
                    req_addr[r]  = AW'($urandom);
                    req_data[r]  = DW'($urandom);
                end
            step();
        end
        idle(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < int'(NR); i++)
            check($sformatf("regfile[%0d]", i), 32'(rf[i]), 32'(rf_exp[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
